// File: rtl/alu_cmd_executor.sv
// alu_cmd_executor: ALU command execution unit with iterative shift-add multiply.
// Optional macro ALU_MUL_HI_EN adds result_hi (upper half of the full MUL product).
module alu_cmd_executor #(
  parameter int WIDTH   = 16,
  parameter int SHAMT_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       alu_cmd,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
`ifdef ALU_MUL_HI_EN
  output logic [WIDTH-1:0] result_hi,
`endif
  output logic             zero,
  output logic             busy
);
`ifdef ALU_MUL_HI_EN
  localparam int PW = 2 * WIDTH;
`else
  localparam int PW = WIDTH;
`endif
  localparam int CW = $clog2(WIDTH + 1);
  typedef enum logic [1:0] {IDLE, MUL, HOLD} state_t;
  state_t state, state_n;
  logic [PW-1:0] mcand, prod;
  logic [WIDTH-1:0] mplier, alu_res;
  logic [CW-1:0] count;
  logic [SHAMT_W-1:0] sh;
  logic accept, is_mul, pending, load_mul;
  assign sh       = b[SHAMT_W-1:0];
  assign is_mul   = alu_cmd == 4'b1000;
  assign pending  = out_valid && !out_ready;
  assign in_ready = state == IDLE && !pending;
  assign accept   = in_valid && in_ready;
  assign busy     = state == MUL;
  // A finished product loads once the output slot is free: directly from MUL, or from HOLD the cycle after the drain
  assign load_mul = (state == MUL && count == '0 && !pending) || (state == HOLD && !out_valid);
  // Single-cycle ALU result; unused codes fall back to ADD so the result is never undefined
  always_comb begin
    alu_res = a + b;
    case (alu_cmd)
      4'b0001: alu_res = a - b;
      4'b0010: alu_res = a & b;
      4'b0011: alu_res = a | b;
      4'b0100: alu_res = WIDTH'($signed(a) < $signed(b));
      4'b0101: alu_res = a << sh;
      4'b0110: alu_res = a >> sh;
      4'b0111: alu_res = $unsigned($signed(a) >>> sh);
      default: alu_res = a + b;
    endcase
  end
  // Next-state logic: MUL runs until the counter empties, parking in HOLD if the previous result is still unread
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (accept && is_mul) state_n = MUL;
      MUL:     if (count == '0) state_n = pending ? HOLD : IDLE;
      HOLD:    if (!out_valid) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end
  // State register
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_n;
  // Multiplier datapath and registered output slot
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mcand     <= '0;
      mplier    <= '0;
      prod      <= '0;
      count     <= '0;
      result    <= '0;
      zero      <= 1'b1;
      out_valid <= 1'b0;
`ifdef ALU_MUL_HI_EN
      result_hi <= '0;
`endif
    end else begin
      if (accept) begin
        mcand  <= PW'(a);
        mplier <= b;
        prod   <= '0;
        count  <= CW'(WIDTH);
      end else if (state == MUL && count != '0) begin
        if (mplier[0]) prod <= prod + mcand;
        mcand  <= mcand << 1;
        mplier <= mplier >> 1;
        count  <= count - 1'b1;
      end
      if (accept && !is_mul) begin
        result    <= alu_res;
        zero      <= alu_res == '0;
        out_valid <= 1'b1;
`ifdef ALU_MUL_HI_EN
        result_hi <= '0;
`endif
      end else if (load_mul) begin
        result    <= prod[WIDTH-1:0];
        zero      <= prod == '0;
        out_valid <= 1'b1;
`ifdef ALU_MUL_HI_EN
        result_hi <= prod[PW-1:WIDTH];
`endif
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_alu_cmd_executor.sv
// tb_alu_cmd_executor: table-driven and scoreboard bench for alu_cmd_executor
module tb_alu_cmd_executor;
  localparam int W = 16;
  logic clk = 1'b0, rst_n = 1'b0, in_valid = 1'b0, out_ready = 1'b1;
  logic in_ready, out_valid, zero, busy;
  logic [3:0] alu_cmd = '0;
  logic [W-1:0] a = '0, b = '0, result;
`ifdef ALU_MUL_HI_EN
  logic [W-1:0] result_hi;
`endif
  typedef struct { logic [3:0] cmd; logic [W-1:0] a; logic [W-1:0] b; logic [W-1:0] res; logic z; } vec_t;
  typedef struct { logic [W-1:0] res; logic z; } exp_t;
  vec_t vecs[13];
  exp_t sb[$];
  exp_t e_mon;
  int n_chk = 0, n_fail = 0;

  always #5 clk = ~clk;

  alu_cmd_executor #(.WIDTH(W), .SHAMT_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .alu_cmd(alu_cmd), .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
    .result(result),
`ifdef ALU_MUL_HI_EN
    .result_hi(result_hi),
`endif
    .zero(zero), .busy(busy)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard: every transferred result must match the oldest outstanding expectation
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      chk("sb_nonempty", 32'(sb.size() != 0), 1);
      if (sb.size() != 0) begin
        e_mon = sb.pop_front();
        chk("sb_result", result, e_mon.res);
        chk("sb_zero", zero, e_mon.z);
      end
    end
  end

  task automatic issue(input logic [3:0] c, input logic [W-1:0] x, input logic [W-1:0] y,
                       input logic [W-1:0] r, input logic z);
    int t;
    exp_t e;
    in_valid = 1'b1; alu_cmd = c; a = x; b = y;
    t = 0;
    while (!in_ready && t < 50) begin
      @(posedge clk); #1;
      t++;
    end
    chk("issue_ready", in_ready, 1);
    e.res = r; e.z = z;
    sb.push_back(e);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int seen;
    vecs[0]  = '{4'h0, 16'hFFFF, 16'h0001, 16'h0000, 1'b1};
    vecs[1]  = '{4'h1, 16'h0003, 16'h0005, 16'hFFFE, 1'b0};
    vecs[2]  = '{4'h4, 16'h8000, 16'h0001, 16'h0001, 1'b0};
    vecs[3]  = '{4'h4, 16'h0001, 16'h8000, 16'h0000, 1'b1};
    vecs[4]  = '{4'h7, 16'h8000, 16'h0004, 16'hF800, 1'b0};
    vecs[5]  = '{4'h6, 16'h8000, 16'h0004, 16'h0800, 1'b0};
    vecs[6]  = '{4'h5, 16'h0001, 16'h0013, 16'h0008, 1'b0};
    vecs[7]  = '{4'h2, 16'hF0F0, 16'hFF00, 16'hF000, 1'b0};
    vecs[8]  = '{4'h3, 16'h00F0, 16'h0F00, 16'h0FF0, 1'b0};
    vecs[9]  = '{4'hB, 16'h0002, 16'h0003, 16'h0005, 1'b0};
    vecs[10] = '{4'hF, 16'hFFFF, 16'hFFFF, 16'hFFFE, 1'b0};
    vecs[11] = '{4'h7, 16'h7FFF, 16'h000F, 16'h0000, 1'b1};
    vecs[12] = '{4'h5, 16'h0001, 16'h000F, 16'h8000, 1'b0};

    // reset values
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_result", result, 0);
    chk("rst_zero", zero, 1);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    chk("rst_in_ready", in_ready, 1);

    // table vectors, back to back
    foreach (vecs[i]) issue(vecs[i].cmd, vecs[i].a, vecs[i].b, vecs[i].res, vecs[i].z);
    repeat (2) @(posedge clk);
    #1;
    chk("table_drained", out_valid, 0);

    // streaming ADD/OR/AND on consecutive cycles
    issue(4'h0, 16'd5, 16'd6, 16'd11, 1'b0);
    chk("stream_v0", out_valid, 1);
    chk("stream_r0", result, 16'd11);
    issue(4'h3, 16'h00F0, 16'h000F, 16'h00FF, 1'b0);
    chk("stream_v1", out_valid, 1);
    chk("stream_r1", result, 16'h00FF);
    issue(4'h2, 16'h0FF0, 16'h00F0, 16'h00F0, 1'b0);
    chk("stream_v2", out_valid, 1);
    chk("stream_r2", result, 16'h00F0);
    @(posedge clk); #1;

    // multiply latency: 300*500 mod 2^16
    issue(4'h8, 16'd300, 16'd500, 16'h49F0, 1'b0);
    for (int k = 1; k <= 17; k++) begin
      @(posedge clk); #1;
      chk($sformatf("mul_valid_c%0d", k), out_valid, 32'(k == 17));
      chk($sformatf("mul_busy_c%0d", k), busy, 32'(k <= 16));
      if (k <= 16) chk($sformatf("mul_inready_c%0d", k), in_ready, 0);
    end
    chk("mul_result", result, 16'h49F0);
`ifdef ALU_MUL_HI_EN
    chk("mul_result_hi", result_hi, 16'h0002);
`endif
    @(posedge clk); #1;

    // backpressure: held ADD result blocks a following MUL
    out_ready = 1'b0;
    issue(4'h0, 16'd1, 16'd1, 16'd2, 1'b0);
    in_valid = 1'b1; alu_cmd = 4'h8; a = 16'd2; b = 16'd3;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      chk("bp_in_ready", in_ready, 0);
      chk("bp_out_valid", out_valid, 1);
      chk("bp_result", result, 16'd2);
      chk("bp_busy", busy, 0);
    end
    out_ready = 1'b1;
    #1;
    chk("bp_release_ready", in_ready, 1);
    e_mon.res = 16'd6; e_mon.z = 1'b0;
    sb.push_back(e_mon);
    @(posedge clk); #1;
    in_valid = 1'b0;
    for (int k = 1; k <= 17; k++) begin
      @(posedge clk); #1;
      chk($sformatf("bp_mul_valid_c%0d", k), out_valid, 32'(k == 17));
    end
    chk("bp_mul_result", result, 16'd6);
`ifdef ALU_MUL_HI_EN
    chk("bp_mul_result_hi", result_hi, 16'd0);
`endif
    @(posedge clk); #1;

    // reset in the middle of a multiply
    issue(4'h8, 16'd7, 16'd9, 16'd63, 1'b0);
    repeat (5) @(posedge clk);
    #1;
    chk("midmul_busy_before", busy, 1);
    rst_n = 1'b0;
    #1;
    sb.delete();
    chk("midmul_out_valid", out_valid, 0);
    chk("midmul_busy", busy, 0);
    chk("midmul_result", result, 0);
    chk("midmul_zero", zero, 1);
    @(negedge clk) rst_n = 1'b1;
    #1;
    chk("midmul_in_ready", in_ready, 1);
    seen = 0;
    repeat (20) begin
      @(posedge clk); #1;
      if (out_valid) seen++;
    end
    chk("midmul_no_stale", seen, 0);

    // post-reset operation still works
    issue(4'h1, 16'd10, 16'd10, 16'd0, 1'b1);
    chk("post_rst_zero", zero, 1);
    repeat (3) @(posedge clk);
    #1;
    chk("sb_empty_end", sb.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/alu_cmd_executor.md
Name: alu_cmd_executor

Overview:
- Execution unit on the consuming side of the 4-bit ALU command bus produced by the opcode decoder in the 16-bit MIPS datapath.
- Accepts a command and two operands over a valid/ready handshake and executes it.
- Single-cycle ops take one cycle; multiply runs iteratively as shift-add.
- Returns a registered result plus zero flag over a second valid/ready handshake to the writeback stage.

Parameters:
- WIDTH, 16, operand/result width in bits.
- SHAMT_W, 4, shift-amount bits taken from b[SHAMT_W-1:0].

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  command/operands valid.
- in_ready  output  1  unit can accept a command this cycle.
- alu_cmd  input  4  command code.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts result.
- result  output  WIDTH  result (low WIDTH bits).
- zero  output  1  result == 0.
- busy  output  1  multiply in progress.

Behaviour:
- Command encoding:
  - 0000 ADD, 0001 SUB (a-b), 0010 AND, 0011 OR.
  - 0100 SLT (signed a<b gives 1, else 0), 0101 SLL, 0110 SRL, 0111 SRA.
  - 1000 MUL (unsigned, low WIDTH bits).
  - 1001-1111 execute as ADD.
- Arithmetic wraps modulo 2^WIDTH; no overflow flag.
- Shifts use b[SHAMT_W-1:0]; SRA replicates a[WIDTH-1].
- States: IDLE, MUL, HOLD.
- in_ready = (state==IDLE) && (!out_valid || out_ready).
- Accept on in_valid && in_ready; operands and command are captured at the accepting edge.
- Non-MUL: result, zero and out_valid=1 are registered at the accepting edge. Latency 1 cycle; back-to-back throughput 1 per cycle when out_ready is held high.
- MUL: at accept, load multiplicand=a, multiplier=b, product=0, count=WIDTH, and go to MUL; busy=1.
  - Each MUL cycle: if multiplier[0], product += multiplicand; multiplicand <<= 1; multiplier >>= 1; count -= 1.
  - When count reaches 0, latch product into result and set out_valid=1. If the previous result is still pending (out_valid && !out_ready), go to HOLD instead.
  - Latency from accept to out_valid: WIDTH+1 cycles.
- HOLD: keep the finished product internally. When the pending result is taken, load the new result the next cycle, then return to IDLE.
- out_valid stays 1 and result/zero stay stable until the cycle out_valid && out_ready. Then out_valid clears unless a new result loads in that same cycle (simultaneous drain+accept allowed).
- in_valid while in_ready=0: ignored, nothing captured; the upstream stage must hold its values.
- Reset (asynchronous, at any time including mid-multiply):
  - state=IDLE; result=0, zero=1, out_valid=0, busy=0.
  - Internal counters and product clear.
  - in_ready=1 once rst_n deasserts.
- No X propagation: unused command codes never leave result undefined.

Optional Feature:
- Macro ALU_MUL_HI_EN.
- Defined:
  - adds output result_hi (WIDTH), holding the upper WIDTH bits of the 2*WIDTH-bit MUL product.
  - The product register is 2*WIDTH wide.
  - result_hi is 0 for non-MUL commands and 0 on reset.
  - zero reflects the full 2*WIDTH product for MUL.
- Undefined:
  - result_hi port absent; product register is WIDTH bits.
  - zero reflects the low WIDTH bits only.

Test Plan:
- Reset mid-MUL (rst_n low at cycle 5 of a multiply) -> out_valid=0, busy=0, result=0, zero=1 immediately; in_ready=1 after release.
- ADD a=16'hFFFF, b=16'h0001, out_ready=1 -> next cycle result=16'h0000, zero=1; SUB a=3, b=5 -> 16'hFFFE, zero=0.
- SLT a=16'h8000, b=16'h0001 -> result=1. SRA a=16'h8000, b=4 -> 16'hF800. SRL same operands -> 16'h0800. Cmd 1011 with a=2, b=3 -> 5.
- MUL a=300, b=500 -> out_valid exactly 17 cycles after accept; result=16'h49F0 (150000 mod 65536), busy=1 during cycles 1-16, in_ready=0 throughout; with ALU_MUL_HI_EN, result_hi=16'h0002.
- Backpressure: out_ready=0, ADD 1+1 then MUL 2*3 offered -> first result=2 held stable, in_ready=0. MUL not accepted until out_ready pulses. Then result=6 after 17 cycles.
- Streaming: out_ready=1, ADD/OR/AND issued on consecutive cycles -> in_ready stays 1, three results on three consecutive cycles in order.
